pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch_if.sv | 21 ++
 rtl/pc_fetch.sv | 105 ++++++++++
 tb/tb_pc_fetch.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// Instruction-memory read port between the fetch stage (master) and memory (slave).
interface pc_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch.sv
// Fetch stage: PC register, one-entry skid buffer and redirect drain for a
// single-outstanding-request instruction memory.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic              stall,
    pc_fetch_if.master        imem,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_pc_plus4
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_pc_q;
    logic [31:0] pend_q;
    logic        if_valid_q;
    logic [31:0] if_instr_q;
    logic [31:0] if_pc_q;
    logic        slot_free;

    assign pc_d      = pc_q + 32'd4;
    assign slot_free = !if_valid_q || !stall;

    assign imem.imem_req  = !rst && (state_q != HOLD);
    assign imem.imem_addr = pc_q;

    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            pend_q       <= '0;
            if_valid_q   <= 1'b0;
            if_instr_q   <= '0;
            if_pc_q      <= '0;
        end else if (redirect) begin
            // A request still in flight (FETCH or DRAIN, no ack) must finish at its
            // old address, so the target is parked; otherwise it loads pc directly.
            if_valid_q <= 1'b0;
            if (!imem.imem_ack && state_q != HOLD) begin
                pend_q  <= redirect_pc;
                state_q <= DRAIN;
            end else begin
                pc_q    <= redirect_pc;
                state_q <= FETCH;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem.imem_ack) begin
                        pc_q <= pc_d;
                        if (slot_free) begin
                            if_instr_q <= imem.imem_rdata;
                            if_pc_q    <= pc_q;
                            if_valid_q <= 1'b1;
                        end else begin
                            skid_instr_q <= imem.imem_rdata;
                            skid_pc_q    <= pc_q;
                            state_q      <= HOLD;
                        end
                    end else if (if_valid_q && !stall) begin
                        if_valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        if_instr_q <= skid_instr_q;
                        if_pc_q    <= skid_pc_q;
                        if_valid_q <= 1'b1;
                        state_q    <= FETCH;
                    end
                end
                DRAIN: begin
                    if_valid_q <= 1'b0;
                    if (imem.imem_ack) begin
                        pc_q    <= pend_q;
                        state_q <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized bench for pc_fetch against a queue-based model of delivered instructions.
module tb_pc_fetch;

    localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    pc_fetch_if imem_bus ();

    pc_fetch #(.RESET_PC(TB_RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .imem        (imem_bus.master),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: pc, drain flag with parked target, and an in-order queue of fetched
    // instructions not yet consumed (front = presented output, second = skid).
    logic [31:0] m_pc;
    logic        m_drain;
    logic [31:0] m_pend;
    logic [31:0] q_instr[$];
    logic [31:0] q_pc[$];
    logic        m_just_reset;
    logic        m_req;

    function automatic logic model_req();
        return !rst && (q_instr.size() < 2);
    endfunction

    task automatic model_step();
        logic req;
        if (rst) begin
            m_pc = TB_RESET_PC;
            m_drain = 1'b0;
            m_pend = '0;
            q_instr.delete();
            q_pc.delete();
            m_just_reset = 1'b1;
        end else begin
            m_just_reset = 1'b0;
            req = (q_instr.size() < 2);
            if (redirect) begin
                q_instr.delete();
                q_pc.delete();
                if (req && !imem_bus.imem_ack) begin
                    m_drain = 1'b1;
                    m_pend  = redirect_pc;
                end else begin
                    m_drain = 1'b0;
                    m_pc    = redirect_pc;
                end
            end else begin
                if (q_instr.size() > 0 && !stall) begin
                    void'(q_instr.pop_front());
                    void'(q_pc.pop_front());
                end
                if (m_drain) begin
                    if (imem_bus.imem_ack) begin
                        m_pc    = m_pend;
                        m_drain = 1'b0;
                    end
                end else if (req && imem_bus.imem_ack) begin
                    q_instr.push_back(imem_bus.imem_rdata);
                    q_pc.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("imem_req", {31'd0, imem_bus.imem_req}, {31'd0, m_req});
        if (m_req) check_eq("imem_addr", imem_bus.imem_addr, m_pc);
        check_eq("if_valid", {31'd0, if_valid}, {31'd0, (q_instr.size() > 0)});
        if (q_instr.size() > 0) begin
            check_eq("if_instr", if_instr, q_instr[0]);
            check_eq("if_pc", if_pc, q_pc[0]);
            check_eq("if_pc_plus4", if_pc_plus4, q_pc[0] + 32'd4);
        end
        if (m_just_reset) begin
            check_eq("rst_if_instr", if_instr, 32'd0);
            check_eq("rst_if_pc", if_pc, 32'd0);
        end
    endtask

    // Phase mix: streaming, moderate, drain-heavy, with resets, stall-heavy.
    int unsigned ph_cycles[5] = '{300, 800, 800, 800, 600};
    int unsigned ph_ack[5]    = '{100, 50, 20, 60, 100};
    int unsigned ph_stall[5]  = '{0, 40, 20, 30, 60};
    int unsigned ph_redir[5]  = '{0, 10, 25, 10, 5};
    int unsigned ph_rst[5]    = '{0, 0, 0, 3, 1};

    function automatic logic [31:0] pick_target();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 3))
            0: return 32'h0000_0400;
            1: return 32'hFFFF_FFF8;
            2: return r & 32'hFFFF_FFFC;
            default: return r;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        stall = 1'b0;
        imem_bus.imem_ack = 1'b0;
        imem_bus.imem_rdata = '0;
        m_pc = '0;
        m_drain = 1'b0;
        m_pend = '0;
        m_just_reset = 1'b0;

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rst = 1'b1;
            m_req = model_req();
            #1 check_eq("imem_req_in_rst", {31'd0, imem_bus.imem_req}, 32'd0);
            @(posedge clk);
            model_step();
        end

        for (int p = 0; p < 5; p++) begin
            for (int unsigned c = 0; c < ph_cycles[p]; c++) begin
                @(negedge clk);
                rst = ($urandom_range(0, 99) < ph_rst[p]);
                m_req = model_req();
                stall = ($urandom_range(0, 99) < ph_stall[p]);
                redirect = ($urandom_range(0, 99) < ph_redir[p]);
                redirect_pc = pick_target();
                imem_bus.imem_ack = m_req && ($urandom_range(0, 99) < ph_ack[p]);
                imem_bus.imem_rdata = $urandom();
                #1 check_outputs();
                @(posedge clk);
                model_step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
